// File: rtl/spart_pkg.sv
// Shared constants and state types for the SPART bus responder.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  localparam int STAT_RDA  = 0;
  localparam int STAT_TBR  = 1;
  localparam int STAT_FERR = 2;

  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// 16x oversample enable generator: down-counter reloaded from the divisor,
// one-cycle en when it hits zero, so the period is divisor+1 clocks.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'd324
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] divisor_i,
  input  logic        load_i,
  output logic        en_o
);

  logic [15:0] cnt_q;

  assign en_o = (cnt_q == 16'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= DIV_RESET;
    end else if (load_i || en_o) begin
      cnt_q <= divisor_i;
    end else begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

endmodule

// File: rtl/spart_sv.sv
// SPART: processor-bus register decode plus 8N1 transmitter and receiver
// running off a shared 16x baud enable.
module spart_sv
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'd324
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_iocs,
  input  logic       i_iorw,
  input  logic [1:0] i_ioaddr,
  inout  wire  [7:0] io_databus,
  output logic       o_rda,
  output logic       o_tbr,
  output logic       o_txd,
  input  logic       i_rxd
);

  logic        rd_en, wr_en;
  logic [15:0] div_q, div_d;
  logic        div_load;
  logic        baud_en;
  logic [7:0]  rd_data;

  tx_state_t   tx_state_q;
  logic [7:0]  tx_sh_q;
  logic [3:0]  tx_tick_q;
  logic [2:0]  tx_bit_q;
  logic        txd_q, tbr_q;
  logic        tx_accept;

  rx_state_t   rx_state_q;
  logic [7:0]  rx_sh_q, rx_buf_q;
  logic [3:0]  rx_tick_q;
  logic [2:0]  rx_bit_q;
  logic        rxd_meta_q, rxd_sync_q, rx_armed_q;
  logic        rda_q, ferr_q;
  logic        rx_stop_end, rx_good, rx_bad;

  assign rd_en = i_iocs & i_iorw;
  assign wr_en = i_iocs & ~i_iorw;

  always_comb begin
    div_d    = div_q;
    div_load = 1'b0;
    if (wr_en && i_ioaddr == ADDR_DBL) begin
      div_d[7:0] = io_databus;
      div_load   = 1'b1;
    end else if (wr_en && i_ioaddr == ADDR_DBH) begin
      div_d[15:8] = io_databus;
      div_load    = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) div_q <= DIV_RESET;
    else          div_q <= div_d;
  end

  // The counter reloads with the divisor being written this edge.
  spart_baud_gen #(.DIV_RESET(DIV_RESET)) u_baud (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .divisor_i (div_d),
    .load_i    (div_load),
    .en_o      (baud_en)
  );

  assign tx_accept = wr_en && (i_ioaddr == ADDR_DATA) && tbr_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= 8'h00;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      txd_q      <= 1'b1;
      tbr_q      <= 1'b1;
    end else begin
      if (tx_accept) begin
        tx_sh_q <= io_databus;
        tbr_q   <= 1'b0;
      end
      unique case (tx_state_q)
        TX_IDLE: begin
          if (baud_en && !tbr_q) begin
            tx_state_q <= TX_START;
            txd_q      <= 1'b0;
            tx_tick_q  <= 4'd0;
          end
        end
        TX_START: begin
          if (baud_en) begin
            if (tx_tick_q == TICK_LAST) begin
              tx_state_q <= TX_DATA;
              txd_q      <= tx_sh_q[0];
              tx_tick_q  <= 4'd0;
              tx_bit_q   <= 3'd0;
            end else begin
              tx_tick_q <= tx_tick_q + 4'd1;
            end
          end
        end
        TX_DATA: begin
          if (baud_en) begin
            if (tx_tick_q == TICK_LAST) begin
              tx_tick_q <= 4'd0;
              if (tx_bit_q == 3'd7) begin
                tx_state_q <= TX_STOP;
                txd_q      <= 1'b1;
              end else begin
                tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                txd_q    <= tx_sh_q[1];
                tx_bit_q <= tx_bit_q + 3'd1;
              end
            end else begin
              tx_tick_q <= tx_tick_q + 4'd1;
            end
          end
        end
        TX_STOP: begin
          if (baud_en) begin
            if (tx_tick_q == TICK_LAST) begin
              tx_state_q <= TX_IDLE;
              tbr_q      <= 1'b1;
            end else begin
              tx_tick_q <= tx_tick_q + 4'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= i_rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  // rx_armed_q blocks a new start until the line has been seen idle after a frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_sh_q    <= 8'h00;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_armed_q <= 1'b0;
    end else begin
      unique case (rx_state_q)
        RX_IDLE: begin
          if (rxd_sync_q) rx_armed_q <= 1'b1;
          if (baud_en && !rxd_sync_q && rx_armed_q) begin
            rx_state_q <= RX_START;
            rx_tick_q  <= 4'd0;
          end
        end
        RX_START: begin
          if (baud_en) begin
            if (rx_tick_q == TICK_MID) begin
              rx_tick_q  <= 4'd0;
              rx_bit_q   <= 3'd0;
              rx_state_q <= rxd_sync_q ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick_q <= rx_tick_q + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (baud_en) begin
            if (rx_tick_q == TICK_LAST) begin
              rx_tick_q <= 4'd0;
              rx_sh_q   <= {rxd_sync_q, rx_sh_q[7:1]};
              rx_bit_q  <= rx_bit_q + 3'd1;
              if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            end else begin
              rx_tick_q <= rx_tick_q + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (baud_en) begin
            if (rx_tick_q == TICK_LAST) begin
              rx_state_q <= RX_IDLE;
              rx_armed_q <= 1'b0;
            end else begin
              rx_tick_q <= rx_tick_q + 4'd1;
            end
          end
        end
      endcase
    end
  end

  assign rx_stop_end = (rx_state_q == RX_STOP) && baud_en && (rx_tick_q == TICK_LAST);
  assign rx_good     = rx_stop_end && rxd_sync_q;
  assign rx_bad      = rx_stop_end && !rxd_sync_q;

  // Set wins over the read-to-clear on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_buf_q <= 8'h00;
      rda_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (rx_good) begin
        rx_buf_q <= rx_sh_q;
        rda_q    <= 1'b1;
      end else if (rd_en && i_ioaddr == ADDR_DATA) begin
        rda_q <= 1'b0;
      end
      if (rx_bad) ferr_q <= 1'b1;
      else if (rd_en && i_ioaddr == ADDR_STATUS) ferr_q <= 1'b0;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    unique case (i_ioaddr)
      ADDR_DATA:   rd_data = rx_buf_q;
      ADDR_STATUS: begin
        rd_data[STAT_RDA]  = rda_q;
        rd_data[STAT_TBR]  = tbr_q;
        rd_data[STAT_FERR] = ferr_q;
      end
      ADDR_DBL:    rd_data = div_q[7:0];
      ADDR_DBH:    rd_data = div_q[15:8];
    endcase
  end

  assign io_databus = rd_en ? rd_data : 8'hzz;

  assign o_rda = rda_q;
  assign o_tbr = tbr_q;
  assign o_txd = txd_q;

endmodule

// File: tb/tb_spart_sv.sv
// Self-checking bench for spart_sv: bus accesses, TX/RX frames against a
// bit-level reference of the 8N1 format at 64 clocks per bit (divisor 3).
module tb_spart_sv;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  logic       tb_drv;
  logic [7:0] tb_dat;
  wire  [7:0] databus;
  logic       rda, tbr, txd;
  logic       rxd_drv, loopback;
  wire        rxd_line;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  assign databus  = tb_drv ? tb_dat : 8'bz;
  assign rxd_line = loopback ? txd : rxd_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spart_sv dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_iocs     (iocs),
    .i_iorw     (iorw),
    .i_ioaddr   (ioaddr),
    .io_databus (databus),
    .o_rda      (rda),
    .o_tbr      (tbr),
    .o_txd      (txd),
    .i_rxd      (rxd_line)
  );

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_dat = d; tb_drv = 1'b1;
    @(negedge clk);
    iocs = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd_drv = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (24) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [7:0] r;
    int k;
    rst_n = 1'b0; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
    tb_drv = 1'b0; tb_dat = 8'h00; rxd_drv = 1'b1; loopback = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if ({txd, tbr, rda} !== 3'b110) begin n_fail++; $display("FAIL reset_outputs: txd/tbr/rda=%b want 110", {txd, tbr, rda}); end
    rst_n = 1'b1;
    bus_read(2'b10, r);
    n_tests++; if (r !== 8'h44) begin n_fail++; $display("FAIL reset_dbl: got %h want 44", r); end
    bus_read(2'b11, r);
    n_tests++; if (r !== 8'h01) begin n_fail++; $display("FAIL reset_dbh: got %h want 01", r); end
    // get TX and RX mid-frame, then reset
    bus_write(2'b00, 8'h5A);
    k = 0;
    while (txd !== 1'b0 && k < 400) begin @(negedge clk); k++; end
    n_tests++; if (k >= 400) begin n_fail++; $display("FAIL reset_prep_start: txd never went low"); end
    rxd_drv = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if ({txd, tbr, rda} !== 3'b110) begin n_fail++; $display("FAIL reset_midframe: txd/tbr/rda=%b want 110", {txd, tbr, rda}); end
    tb_dat = 8'h96; tb_drv = 1'b1;
    #1;
    n_tests++; if (databus !== 8'h96) begin n_fail++; $display("FAIL reset_bus_released: got %h want 96", databus); end
    tb_drv = 1'b0; rxd_drv = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(2'b01, r);
    n_tests++; if (r !== 8'h02) begin n_fail++; $display("FAIL reset_status: got %h want 02", r); end
    k = 0;
    repeat (400) begin @(negedge clk); if (txd !== 1'b1) k++; end
    n_tests++; if (k != 0) begin n_fail++; $display("FAIL reset_tx_idle: txd low %0d cycles want 0", k); end
  endtask

  task automatic test_divisor;
    logic [7:0] r;
    bus_write(2'b10, 8'd3);
    bus_write(2'b11, 8'd0);
    bus_read(2'b10, r);
    n_tests++; if (r !== 8'h03) begin n_fail++; $display("FAIL div_dbl: got %h want 03", r); end
    bus_read(2'b11, r);
    n_tests++; if (r !== 8'h00) begin n_fail++; $display("FAIL div_dbh: got %h want 00", r); end
  endtask

  task automatic test_tx(input logic [7:0] d, input bit try_overwrite);
    int t_w, k, delta, lows;
    logic exp;
    bus_write(2'b00, d);
    t_w = cyc;
    n_tests++; if (tbr !== 1'b0) begin n_fail++; $display("FAIL tx_tbr_fall: got %b want 0", tbr); end
    k = 0;
    while (txd !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    n_tests++; if (k >= 20) begin n_fail++; $display("FAIL tx_start_timeout: no start bit within 20 clocks"); end
    for (int i = 0; i < 10; i++) begin
      if (i == 0) repeat (BIT_CLKS / 2) @(negedge clk);
      else if (i == 2 && try_overwrite) begin
        bus_write(2'b00, ~d);
        repeat (BIT_CLKS - 2) @(negedge clk);
      end else repeat (BIT_CLKS) @(negedge clk);
      if (i == 0) exp = 1'b0;
      else if (i == 9) exp = 1'b1;
      else exp = ((d >> (i - 1)) & 8'h01) != 0;
      n_tests++; if (txd !== exp) begin n_fail++; $display("FAIL tx_bit%0d data=%h: got %b want %b", i, d, txd, exp); end
    end
    k = 0;
    while (tbr !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    delta = cyc - t_w;
    n_tests++; if (tbr !== 1'b1 || delta < 640 || delta > 644) begin n_fail++; $display("FAIL tx_tbr_return: tbr=%b after %0d clocks want 1 within 640..644", tbr, delta); end
    lows = 0;
    repeat (150) begin @(negedge clk); if (txd !== 1'b1) lows++; end
    n_tests++; if (lows != 0 || tbr !== 1'b1) begin n_fail++; $display("FAIL tx_idle_after: txd low %0d cycles tbr=%b want 0 and 1", lows, tbr); end
  endtask

  task automatic test_rx(input logic [7:0] d);
    logic [7:0] r;
    send_frame(d, 1'b1);
    n_tests++; if (rda !== 1'b1) begin n_fail++; $display("FAIL rx_rda_set data=%h: got %b want 1", d, rda); end
    bus_read(2'b00, r);
    n_tests++; if (r !== d) begin n_fail++; $display("FAIL rx_data: got %h want %h", r, d); end
    n_tests++; if (rda !== 1'b0) begin n_fail++; $display("FAIL rx_rda_clear: got %b want 0", rda); end
  endtask

  task automatic test_false_start;
    logic [7:0] r;
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (16) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (120) @(negedge clk);
    n_tests++; if (rda !== 1'b0) begin n_fail++; $display("FAIL false_start_rda: got %b want 0", rda); end
    bus_read(2'b01, r);
    n_tests++; if (r !== 8'h02) begin n_fail++; $display("FAIL false_start_status: got %h want 02", r); end
    test_rx(8'h81);
  endtask

  task automatic test_framing_error;
    logic [7:0] r;
    send_frame(8'h55, 1'b0);
    n_tests++; if (rda !== 1'b0) begin n_fail++; $display("FAIL ferr_rda: got %b want 0", rda); end
    bus_read(2'b01, r);
    n_tests++; if (r !== 8'h06) begin n_fail++; $display("FAIL ferr_status1: got %h want 06", r); end
    bus_read(2'b01, r);
    n_tests++; if (r !== 8'h02) begin n_fail++; $display("FAIL ferr_status2: got %h want 02", r); end
  endtask

  task automatic test_overrun;
    logic [7:0] r;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    n_tests++; if (rda !== 1'b1) begin n_fail++; $display("FAIL overrun_rda: got %b want 1", rda); end
    bus_read(2'b00, r);
    n_tests++; if (r !== 8'h22) begin n_fail++; $display("FAIL overrun_data: got %h want 22", r); end
    n_tests++; if (rda !== 1'b0) begin n_fail++; $display("FAIL overrun_rda_clear: got %b want 0", rda); end
  endtask

  task automatic test_loopback;
    logic [7:0] r;
    int k;
    loopback = 1'b1;
    repeat (20) @(negedge clk);
    bus_write(2'b00, 8'hC3);
    k = 0;
    while (rda !== 1'b1 && k < 1500) begin @(negedge clk); k++; end
    n_tests++; if (rda !== 1'b1) begin n_fail++; $display("FAIL loop_rda: got %b want 1 within 1500 clocks", rda); end
    bus_read(2'b00, r);
    n_tests++; if (r !== 8'hC3) begin n_fail++; $display("FAIL loop_data: got %h want c3", r); end
    repeat (100) @(negedge clk);
    loopback = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    test_reset();
    test_divisor();
    test_tx(8'hA5, 1'b1);
    rb = 8'($urandom_range(0, 255));
    test_tx(rb, 1'b0);
    test_rx(8'h3C);
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom_range(0, 255));
      test_rx(rb);
    end
    test_false_start();
    test_framing_error();
    test_overrun();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spart_sv.md
Name: spart_sv

Overview:
- Special-purpose asynchronous receiver/transmitter. It is the bus-responder end of the processor I/O interface (iocs/iorw/ioaddr/databus/rda/tbr).
- The processor-side driver reads received bytes and writes bytes to transmit through a shared tri-state 8-bit databus.
- Block contains:
  - a programmable baud generator at 16x oversample,
  - an 8N1 transmitter,
  - an 8N1 receiver,
  - the bus register decode.

Parameters:
- DIV_RESET, 16'd324, baud divisor after reset. Enable period is DIV_RESET+1 clocks, giving about 9600 baud x16 at 50 MHz.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous, active-low reset
- i_iocs  input  1  chip select; a bus access happens on each clock edge where it is high
- i_iorw  input  1  1 = read (SPART drives databus), 0 = write
- i_ioaddr  input  2  register select: 00 data, 01 status, 10 DB low, 11 DB high
- io_databus  inout  8  bidirectional data
- o_rda  output  1  receive data available
- o_tbr  output  1  transmit buffer ready
- o_txd  output  1  serial out, idles high
- i_rxd  input  1  serial in, asynchronous

Behaviour:
- Reset values: o_txd=1, o_tbr=1, o_rda=0, ferr=0, divisor=DIV_RESET, databus released (Z), TX and RX in IDLE.
- Bus drive:
  - io_databus is driven only while i_iocs && i_iorw; otherwise it is Z.
  - Read data is combinational from the current register state. The initiator samples it on the same edge.
- Read map:
  - 00 = rx_buf
  - 01 = {5'b0, ferr, tbr, rda}
  - 10 = DB low
  - 11 = DB high
- Read side effects:
  - Read of 00 clears rda at that edge.
  - Read of 01 clears ferr at that edge.
- Write map:
  - 00: loads tx shift register only if tbr=1; write while tbr=0 is ignored.
  - 10 / 11: update the divisor byte and reload the baud counter at that edge.
- Baud generator:
  - 16-bit down-counter loaded with {DBH,DBL}.
  - Emits a 1-cycle en pulse when it reaches 0, then reloads. Period = divisor+1 clocks.
  - Divisor 0 means en every cycle.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Accepted write sets tbr=0 on the next cycle.
  - Transition IDLE->START happens on the next en; o_txd=0.
  - Each bit lasts 16 en pulses. DATA shifts LSB first, 8 bits, with a 3-bit bit counter and a 4-bit tick counter.
  - STOP drives 1 for 16 en, then IDLE with tbr=1.
- RX synchronisation: i_rxd passes through a 2-flop synchronizer before use; all RX logic uses the synchronized value.
- RX FSM: IDLE -> START -> DATA -> STOP.
  - IDLE: on en with rxd=0, go to START.
  - START: after 8 en (mid-bit), if rxd=0 go to DATA, else go back to IDLE (false start, nothing flagged).
  - DATA: samples every 16 en, LSB first, 8 bits.
  - STOP: samples after 16 en.
    - If 1: rx_buf <= shift, rda <= 1.
    - If 0: byte discarded, ferr <= 1.
  - Either way return to IDLE, which requires rxd=1 before a new start is armed.
- Boundary conditions:
  - New byte completes while rda=1: overwrite rx_buf, rda stays 1.
  - Same-edge read of 00 and byte completion: read returns the old byte, set wins (rda stays 1, rx_buf holds the new byte).
  - Same-edge status read and ferr set: set wins.
  - Divisor write mid-frame: takes effect immediately; the frame is not aborted.
  - Reset mid-frame: TX and RX return to IDLE immediately; o_txd=1.
- o_rda and o_tbr are registered status bits, identical to status bits 0 and 1.

Decomposition:
- spart_pkg holds:
  - address constants ADDR_DATA / ADDR_STATUS / ADDR_DBL / ADDR_DBH,
  - status bit indices,
  - OVERSAMPLE=16,
  - tx_state_t and rx_state_t enums.
- One natural sub-module: spart_baud_gen (divisor in, load strobe in, en out).
- TX, RX and bus decode stay in spart_sv.

Test Plan:
- Reset: assert i_rst_n=0 mid-operation -> o_txd=1, o_tbr=1, o_rda=0, databus Z, status read after release = 8'h02.
- TX 0xA5:
  - Stimulus: write DBL=3, DBH=0, then write 0xA5 to 00.
  - tbr falls the next cycle.
  - o_txd shows start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 64 clocks.
  - tbr returns 1 within 640-644 clocks of the write.
  - A second write during the frame is ignored.
- RX 0x3C with divisor 3:
  - Drive the 8N1 frame on i_rxd at 64 clocks/bit -> rda=1 after the stop bit.
  - Read 00 returns 0x3C; rda is 0 next cycle.
- False start: 16-clock low glitch on i_rxd -> no rda, no ferr, receiver accepts the next valid frame 0x81.
- Framing error: frame 0x55 with stop bit 0 -> rda stays 0; status read = 8'h06; next status read = 8'h02.
- Overrun and loopback:
  - Two frames 0x11 then 0x22 with no read -> read 00 returns 0x22, rda cleared.
  - o_txd tied to i_rxd: write 0xC3 -> rda asserts, read returns 0xC3.
